// File: rtl/cam_frame_writer_pkg.sv
// rtl/cam_frame_writer_pkg.sv - shared state encoding, pixel bit positions and screen defaults
package cam_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        BYTE1,
        BYTE2
    } state_t;

    localparam int CAM_SCREEN_X_DEFAULT = 160;
    localparam int CAM_SCREEN_Y_DEFAULT = 120;

    // RGB111 output positions
    localparam int RGB111_R = 2;
    localparam int RGB111_G = 1;
    localparam int RGB111_B = 0;

    // MSB of each RGB565 field within the first (hi) and second (lo) byte
    localparam int HI_R_MSB = 7;
    localparam int HI_G_MSB = 2;
    localparam int LO_B_MSB = 4;

endpackage

// File: rtl/cam_frame_writer_sync_edge.sv
// rtl/cam_frame_writer_sync_edge.sv - 2-flop synchronizer with rise/fall detect
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - camera RGB565 capture, RGB111 reduction and frame buffer writes
module cam_frame_writer
    import cam_frame_writer_pkg::*;
#(
    parameter int AW           = 15,
    parameter int DW           = 3,
    parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEFAULT,
    parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pclk,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          init,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(CAM_SCREEN_X * CAM_SCREEN_Y - 1);

    logic       pclk_rise, pclk_fall_unused;
    logic       vsync_rise, vsync_fall;
    logic       href_s1, href_s;
    logic [7:0] px_s1, px_s;
    logic [7:0] hi;
    logic       full;
    state_t     state;
    logic [DW-1:0] pixel;
    logic       unused_px_bits;

    sync_edge u_pclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pclk),
        .rise (pclk_rise),
        .fall (pclk_fall_unused)
    );

    sync_edge u_vsync_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (vsync),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    // Same depth as the pclk path so data and its strobe stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            href_s1 <= 1'b0;
            href_s  <= 1'b0;
            px_s1   <= '0;
            px_s    <= '0;
        end else begin
            href_s1 <= href;
            href_s  <= href_s1;
            px_s1   <= px_data;
            px_s    <= px_s1;
        end
    end

    always_comb begin
        pixel           = '0;
        pixel[RGB111_R] = hi[HI_R_MSB];
        pixel[RGB111_G] = hi[HI_G_MSB];
        pixel[RGB111_B] = px_s[LO_B_MSB];
    end

    assign unused_px_bits = ^{hi, px_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hi             <= '0;
            full           <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            DP_RAM_regW    <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            DP_RAM_regW <= 1'b0;
            frame_done  <= 1'b0;

            // Advance after the write cycle; the last address saturates
            if (DP_RAM_regW) begin
                if (DP_RAM_addr_in == LAST_ADDR)
                    full <= 1'b1;
                else
                    DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (init)
                        state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        DP_RAM_addr_in <= '0;
                        full           <= 1'b0;
                        state          <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= init ? WAIT_FRAME : IDLE;
                    end else if (pclk_rise && href_s) begin
                        hi    <= px_s;
                        state <= BYTE2;
                    end
                end
                BYTE2: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= init ? WAIT_FRAME : IDLE;
                    end else if (!href_s) begin
                        state <= BYTE1;
                    end else if (pclk_rise) begin
                        if (!full) begin
                            DP_RAM_regW    <= 1'b1;
                            DP_RAM_data_in <= pixel;
                        end
                        state <= BYTE1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - scoreboard bench for cam_frame_writer
module tb_cam_frame_writer;

    localparam int AW   = 8;
    localparam int DW   = 3;
    localparam int SX   = 20;
    localparam int SY   = 10;
    localparam int LAST = SX * SY - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pclk = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic          init = 1'b0;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [DW-1:0] DP_RAM_data_in;
    logic          DP_RAM_regW;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int n_frames = 0;
    int last_addr = -1;

    logic [AW+DW-1:0] exp_q[$];
    int exp_addr = 0;
    bit model_full = 1'b0;
    bit cap_en = 1'b0;

    cam_frame_writer #(
        .AW           (AW),
        .DW           (DW),
        .CAM_SCREEN_X (SX),
        .CAM_SCREEN_Y (SY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pclk           (pclk),
        .vsync          (vsync),
        .href           (href),
        .px_data        (px_data),
        .init           (init),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_data_in (DP_RAM_data_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .frame_done     (frame_done)
    );

    always #7 clk = ~clk;

    // Scoreboard: every write must match the oldest expected pixel
    always @(negedge clk) begin
        if (DP_RAM_regW) begin
            logic [AW+DW-1:0] e;
            n_writes++;
            last_addr = int'(DP_RAM_addr_in);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr %0d data %b, required no write",
                         DP_RAM_addr_in, DP_RAM_data_in);
            end else begin
                e = exp_q.pop_front();
                if ({DP_RAM_addr_in, DP_RAM_data_in} !== e) begin
                    n_err++;
                    $display("FAIL write_value: got addr %0d data %b, required addr %0d data %b",
                             DP_RAM_addr_in, DP_RAM_data_in, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (frame_done) n_frames++;
    end

    task automatic model_pixel(input logic [7:0] h, input logic [7:0] l);
        if (cap_en && !model_full) begin
            exp_q.push_back({AW'(exp_addr), h[7], h[2], l[4]});
            if (exp_addr == LAST) model_full = 1'b1;
            else exp_addr++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        pclk    = 1'b0;
        px_data = b;
        href    = 1'b1;
        #41;
        pclk = 1'b1;
        #41;
    endtask

    task automatic send_pixel(input logic [7:0] h, input logic [7:0] l);
        send_byte(h);
        model_pixel(h, l);
        send_byte(l);
    endtask

    task automatic end_line();
        pclk = 1'b0;
        href = 1'b0;
        #200;
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        #200;
        vsync = 1'b0;
        exp_addr   = 0;
        model_full = 1'b0;
        cap_en     = init;
        #300;
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        #300;
    endtask

    task automatic send_lines(input int lines, input logic [7:0] h, input logic [7:0] l);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < SX; x++) send_pixel(h, l);
            end_line();
        end
    endtask

    task automatic check_counts(input string name, input int w0, input int f0,
                                input int exp_w, input int exp_f);
        n_cmp++;
        if (n_writes - w0 !== exp_w) begin
            n_err++;
            $display("FAIL %s_writes: got %0d, required %0d", name, n_writes - w0, exp_w);
        end
        n_cmp++;
        if (n_frames - f0 !== exp_f) begin
            n_err++;
            $display("FAIL %s_frame_done: got %0d, required %0d", name, n_frames - f0, exp_f);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL %s_pending: got %0d missing writes, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #50;
        n_cmp++;
        if ({DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done});
        end
        rst = 1'b0;
        #100;
    endtask

    task automatic test_full_frame();
        int w0, f0;
        init = 1'b1;
        #100;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_lines(SY, 8'hF8, 8'h00);
        frame_end();
        check_counts("full_frame", w0, f0, SX * SY, 1);
        n_cmp++;
        if (last_addr !== LAST) begin
            n_err++;
            $display("FAIL full_frame_last_addr: got %0d, required %0d", last_addr, LAST);
        end
        n_cmp++;
        if (DP_RAM_addr_in !== AW'(LAST)) begin
            n_err++;
            $display("FAIL full_frame_saturate: got %0d, required %0d", DP_RAM_addr_in, LAST);
        end
    endtask

    task automatic test_colour();
        int w0, f0;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_pixel(8'h07, 8'hE0);
        send_pixel(8'h00, 8'h1F);
        send_pixel(8'hFF, 8'hFF);
        send_pixel(8'h7B, 8'hEF);
        end_line();
        frame_end();
        check_counts("colour", w0, f0, 4, 1);
    endtask

    task automatic test_odd_line();
        int w0, f0;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_pixel(8'hF8, 8'h00);
        send_pixel(8'h07, 8'hE0);
        send_byte(8'hFF);
        end_line();
        check_counts("odd_line_first", w0, f0, 2, 0);
        send_pixel(8'h00, 8'h1F);
        send_pixel(8'h84, 8'h10);
        end_line();
        frame_end();
        check_counts("odd_line", w0, f0, 4, 1);
    endtask

    task automatic test_overflow();
        int w0, f0;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_lines(SY + 1, 8'h04, 8'h10);
        frame_end();
        check_counts("overflow", w0, f0, SX * SY, 1);
        n_cmp++;
        if (last_addr !== LAST) begin
            n_err++;
            $display("FAIL overflow_last_addr: got %0d, required %0d", last_addr, LAST);
        end
    endtask

    task automatic test_init_drop();
        int w0, f0;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_lines(2, 8'h80, 8'h00);
        init = 1'b0;
        send_lines(1, 8'h80, 8'h10);
        frame_end();
        check_counts("init_drop_frame", w0, f0, 3 * SX, 1);
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_lines(2, 8'hFF, 8'hFF);
        frame_end();
        check_counts("init_drop_next", w0, f0, 0, 0);
        init = 1'b1;
        #100;
    endtask

    task automatic test_reset_midline();
        int w0, f0;
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_pixel(8'hFF, 8'hFF);
        send_pixel(8'hFF, 8'hFF);
        send_pixel(8'hFF, 8'hFF);
        send_byte(8'hFF);
        #100;
        check_counts("reset_pre", w0, f0, 3, 0);
        rst = 1'b1;
        #20;
        n_cmp++;
        if ({DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_midline_outputs: got %h, required 0",
                     {DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW, frame_done});
        end
        cap_en = 1'b0;
        #30;
        rst = 1'b0;
        w0 = n_writes; f0 = n_frames;
        send_byte(8'hFF);
        send_pixel(8'hFF, 8'hFF);
        end_line();
        send_lines(1, 8'hFF, 8'hFF);
        frame_end();
        check_counts("reset_aborted_frame", w0, f0, 0, 0);
        w0 = n_writes; f0 = n_frames;
        frame_begin();
        send_pixel(8'h04, 8'h00);
        send_pixel(8'h00, 8'h10);
        end_line();
        frame_end();
        check_counts("reset_next_frame", w0, f0, 2, 1);
        n_cmp++;
        if (last_addr !== 1) begin
            n_err++;
            $display("FAIL reset_restart_addr: got %0d, required 1", last_addr);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_colour();
        test_odd_line();
        test_overflow();
        test_init_drop();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Write-side companion of the VGA frame path: captures RGB565 pixels from an OV7670-style camera bus, reduces each pixel to RGB111 and writes it into the write port of `buffer_ram_dp`. The VGA driver reads the same buffer through the read port. Everything runs in the system clock domain: camera signals are synchronized and their `pclk` edges are detected by oversampling.

## Interface
- `AW`, 15 — buffer address width; must satisfy 2^AW ≥ `CAM_SCREEN_X`*`CAM_SCREEN_Y`.
- `DW`, 3 — pixel width written to the buffer (RGB111).
- `CAM_SCREEN_X`, 160 — pixels per captured line.
- `CAM_SCREEN_Y`, 120 — lines per captured frame.

Ports:
- `clk` in 1 — system clock; same clock as the buffer write port.
- `rst` in 1 — asynchronous, active-high reset.
- `pclk` in 1 — camera pixel clock, asynchronous; frequency ≤ `clk`/3.
- `vsync` in 1 — camera vertical sync, high during vertical blanking.
- `href` in 1 — camera line-valid, high while bytes are valid.
- `px_data` in 8 — camera byte bus, stable around the rising edge of `pclk`.
- `init` in 1 — capture enable (level).
- `DP_RAM_addr_in` out AW — buffer write address.
- `DP_RAM_data_in` out DW — buffer write data, {R,G,B}.
- `DP_RAM_regW` out 1 — one-cycle write strobe.
- `frame_done` out 1 — one-cycle pulse at the end of each captured frame.

## Operation
- **Input synchronization:** `pclk`, `vsync`, `href` and `px_data` each pass through a 2-flop synchronizer, all in parallel.
- **Edge detection:** a third `pclk` register gives `pclk_rise` (sync2 high, sync3 low). The synchronized `vsync` is edge-detected the same way.
- **State machine:**
  - `IDLE`: stays here while `init`=0. Goes to `WAIT_FRAME` when `init`=1.
  - `WAIT_FRAME`: waits for a synchronized `vsync` falling edge. On that edge, address counter ← 0 and go to `BYTE1`.
  - `BYTE1`: on `pclk_rise` with `href`=1, latch the byte into `hi` and go to `BYTE2`.
  - `BYTE2`: on `pclk_rise` with `href`=1, form the pixel from `hi` and the new byte `lo`, issue a write, and return to `BYTE1`. If `href` falls while in `BYTE2`, discard the half pixel and return to `BYTE1`.
- **Pixel reduction:** `DP_RAM_data_in` = {`hi`[7], `hi`[2], `lo`[4]}, i.e. the MSB of R5, of G6 and of B5.
- **Addressing:**
  - Each write uses the current address; the address increments by 1 after the write.
  - At `CAM_SCREEN_X`*`CAM_SCREEN_Y`−1, the write is performed and the counter saturates. Later pixels in the same frame are dropped (no `regW`). There is no wrap within a frame.
- **End of frame:** a synchronized `vsync` rising edge in `BYTE1` or `BYTE2`:
  - pulses `frame_done`;
  - drops any pending half pixel;
  - goes to `WAIT_FRAME` if `init`=1, otherwise to `IDLE`.
  
  Deasserting `init` mid-frame therefore takes effect only at the frame end.
- **Reset:** all outputs are 0 and the state is `IDLE`. This holds for reset asserted at any point, including mid-frame; a partial frame is never completed after reset.

## Timing
- The `pclk` rising edge is detected 3 `clk` cycles after it occurs, ±1 for synchronizer phase.
- `DP_RAM_regW` is high for exactly the one `clk` cycle after the cycle in which the second byte's `pclk_rise` is seen. Address and data are valid in that same cycle.
- The address increment becomes visible in the cycle after `regW`.
- `frame_done` is high in the cycle after the `vsync` rising edge is detected.
- Minimum spacing between writes is 2 `pclk` periods (≥ 6 `clk` cycles).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding (`IDLE`, `WAIT_FRAME`, `BYTE1`, `BYTE2`);
  - `RGB111` bit positions;
  - the `CAM_SCREEN_X`/`CAM_SCREEN_Y` defaults, so `test_VGA` and this block agree.
- One sub-module, `sync_edge`: a 2-flop synchronizer plus rise/fall detect. It is instantiated for `pclk` and for `vsync`. `href` and `px_data` use bare 2-flop synchronizers.
- Top-level integration:
  - `DP_RAM_addr_in`, `DP_RAM_data_in` and `DP_RAM_regW` connect directly to the buffer write port;
  - `init` is tied to a board button.

## Test plan
- **Full frame:** `clk` 75 MHz, `pclk` 12.5 MHz, `init`=1. Drive 120 lines × 320 bytes with pattern `hi`=8'hF8, `lo`=8'h00 (pure red). Required: 19200 `regW` pulses, addresses 0..19199 in order, data 3'b100 on every write, one `frame_done`.
- **Colour mapping:** byte pairs (8'h07,8'hE0) and (8'h00,8'h1F). Required: data 3'b010 and 3'b001.
- **Odd line:** a line with 5 bytes, then `href` low. Required: 2 writes only, next line starts in `BYTE1` with no address gap.
- **Overflow:** a frame of 121 lines. Required: last write at address 19199, no writes for line 121, `frame_done` still pulses.
- **Control and reset:**
  - `init` dropped mid-frame: frame completes, then no writes on the next frame.
  - `rst` pulsed mid-line: outputs 0 within the reset, state `IDLE`, address restarts at 0 on the next captured frame.
